// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register.
// Runs the data-memory access over a req/ack handshake and holds the upstream
// pipeline with Stall while it is outstanding. Misaligned or illegal accesses
// and memory timeouts are squashed into bubbles and latched in a sticky
// AccessErr flag.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WBIn,
  input  logic [1:0]  MIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] WriteDataIn,
  input  logic [4:0]  RegDstIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Stall,
  output logic        AccessErr,
  output logic [1:0]  WBOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [4:0]  RegDstOut
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             errNext;
  logic [1:0]       wbNext;
  logic [31:0]      readDataNext;
  logic [31:0]      aluNext;
  logic [4:0]       regDstNext;
  logic             stallRaw;
  logic             acc;
  logic             bad;

  // A memory op is exactly one of read/write; both set, or a misaligned
  // word address, is an illegal access.
  assign acc = MIn[1] ^ MIn[0];
  assign bad = (MIn == 2'b11) || (acc && (ALUResultIn[1:0] != 2'b00));

  // Stall is combinational from MIn in IDLE, so it must be masked while
  // reset is held to drop immediately with everything else.
  assign Stall = stallRaw & ~rst;

  // State, timeout counter, sticky error and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      AccessErr    <= 1'b0;
      WBOut        <= 2'b00;
      ReadDataOut  <= 32'd0;
      ALUResultOut <= 32'd0;
      RegDstOut    <= 5'd0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      AccessErr    <= errNext;
      WBOut        <= wbNext;
      ReadDataOut  <= readDataNext;
      ALUResultOut <= aluNext;
      RegDstOut    <= regDstNext;
    end
  end

  // Next-state, memory request and MEM/WB next values; defaults form a bubble.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    errNext      = AccessErr;
    wbNext       = 2'b00;
    readDataNext = 32'd0;
    aluNext      = 32'd0;
    regDstNext   = 5'd0;
    stallRaw     = 1'b0;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    MemAddr      = 32'd0;
    MemWData     = 32'd0;

    case (state)
      IDLE: begin
        cntNext = '0;
        if (MIn == 2'b00) begin
          // Plain ALU op: straight through with no extra latency.
          wbNext     = WBIn;
          aluNext    = ALUResultIn;
          regDstNext = RegDstIn;
        end else if (bad) begin
          errNext = 1'b1;
        end else begin
          stallRaw  = 1'b1;
          stateNext = BUSY;
        end
      end

      BUSY: begin
        MemReq   = 1'b1;
        MemWe    = MIn[0];
        MemAddr  = ALUResultIn;
        MemWData = WriteDataIn;
        // Ack is checked before expiry so a last-cycle ack still completes.
        if (MemAck) begin
          wbNext       = WBIn;
          aluNext      = ALUResultIn;
          regDstNext   = RegDstIn;
          readDataNext = MIn[1] ? MemRData : 32'd0;
          stateNext    = IDLE;
          cntNext      = '0;
        end else if (cnt == LAST_CNT) begin
          errNext   = 1'b1;
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          stallRaw = 1'b1;
          cntNext  = cnt + ONE_CNT;
        end
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage. Each instruction is turned into a
// per-cycle schedule (how many cycles it occupies, where the request is
// visible, what MEM/WB holds afterwards); a negedge compare process checks
// every DUT output against that schedule every cycle.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WBIn;
  logic [1:0]  MIn;
  logic [31:0] ALUResultIn;
  logic [31:0] WriteDataIn;
  logic [4:0]  RegDstIn;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        Stall;
  logic        AccessErr;
  logic [1:0]  WBOut;
  logic [31:0] ReadDataOut;
  logic [31:0] ALUResultOut;
  logic [4:0]  RegDstOut;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Expected values for the current cycle.
  logic        eReq, eWe, eStall, eErr;
  logic [31:0] eAddr, eWData, eRd, eAlu;
  logic [1:0]  eWB;
  logic [4:0]  eDst;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .WBIn(WBIn), .MIn(MIn), .ALUResultIn(ALUResultIn),
    .WriteDataIn(WriteDataIn), .RegDstIn(RegDstIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .Stall(Stall), .AccessErr(AccessErr),
    .WBOut(WBOut), .ReadDataOut(ReadDataOut),
    .ALUResultOut(ALUResultOut), .RegDstOut(RegDstOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the schedule.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("MemReq",       {31'd0, MemReq},    {31'd0, eReq});
      chk("MemWe",        {31'd0, MemWe},     {31'd0, eWe});
      chk("MemAddr",      MemAddr,            eAddr);
      chk("MemWData",     MemWData,           eWData);
      chk("Stall",        {31'd0, Stall},     {31'd0, eStall});
      chk("AccessErr",    {31'd0, AccessErr}, {31'd0, eErr});
      chk("WBOut",        {30'd0, WBOut},     {30'd0, eWB});
      chk("ReadDataOut",  ReadDataOut,        eRd);
      chk("ALUResultOut", ALUResultOut,       eAlu);
      chk("RegDstOut",    {27'd0, RegDstOut}, {27'd0, eDst});
    end
  end

  task automatic setBubble();
    eWB = 2'b00; eRd = 32'd0; eAlu = 32'd0; eDst = 5'd0;
  endtask

  task automatic clearModel();
    eReq = 1'b0; eWe = 1'b0; eStall = 1'b0; eErr = 1'b0;
    eAddr = 32'd0; eWData = 32'd0;
    setBubble();
  endtask

  // ackAt: BUSY cycle (1-based) in which MemAck is raised; 0 means never.
  task automatic runInstr(input string tag, input logic [1:0] wb, input logic [1:0] m,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] rdata, input int ackAt);
    bit isBad, isMem, acked;
    int n;
    isBad = (m == 2'b11) || ((m[1] ^ m[0]) && (alu[1:0] != 2'b00));
    isMem = !isBad && (m != 2'b00);
    acked = isMem && ackAt >= 1 && ackAt <= TO;
    if (!isMem)      n = 1;
    else if (acked)  n = ackAt + 1;
    else             n = TO + 1;
    WBIn = wb; MIn = m; ALUResultIn = alu; WriteDataIn = wd; RegDstIn = rd;
    MemRData = rdata;
    for (int c = 0; c < n; c++) begin
      MemAck = isMem && (c >= 1) && (c == ackAt);
      eReq   = isMem && (c >= 1);
      eWe    = eReq && m[0];
      eAddr  = eReq ? alu : 32'd0;
      eWData = eReq ? wd : 32'd0;
      eStall = isMem && (c < n - 1);
      @(posedge clk);
      #1;
      if (c == n - 1) begin
        if (isBad) begin
          setBubble(); eErr = 1'b1;
        end else if (!isMem) begin
          eWB = wb; eRd = 32'd0; eAlu = alu; eDst = rd;
        end else if (acked) begin
          eWB = wb; eRd = m[1] ? rdata : 32'd0; eAlu = alu; eDst = rd;
        end else begin
          setBubble(); eErr = 1'b1;
        end
      end else begin
        setBubble();
      end
    end
    MemAck = 1'b0;
    eReq = 1'b0; eWe = 1'b0; eAddr = 32'd0; eWData = 32'd0; eStall = 1'b0;
    $display("%s: MIn=%b addr=%h cycles=%0d WBOut=%b ReadDataOut=%h AccessErr=%b",
             tag, m, alu, n, WBOut, ReadDataOut, AccessErr);
  endtask

  initial begin
    rst = 1'b1;
    WBIn = 2'b00; MIn = 2'b00; ALUResultIn = 32'd0; WriteDataIn = 32'd0;
    RegDstIn = 5'd0; MemRData = 32'd0; MemAck = 1'b0;
    clearModel();
    #1;
    chk("reset MemReq", {31'd0, MemReq}, 32'd0);
    chk("reset Stall",  {31'd0, Stall},  32'd0);
    chk("reset WBOut",  {30'd0, WBOut},  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checkEn = 1'b1;

    // ALU op pass-through.
    runInstr("alu", 2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd9, 32'h0, 0);
    chk("lit alu WBOut",  {30'd0, WBOut}, 32'd2);
    chk("lit alu ALURes", ALUResultOut,   32'h0000_1234);
    chk("lit alu RegDst", {27'd0, RegDstOut}, 32'd9);

    // Load, ack in 3rd BUSY cycle.
    runInstr("load_ack3", 2'b11, 2'b10, 32'h100, 32'h5555_AAAA, 5'd4, 32'hDEAD_BEEF, 3);
    chk("lit load ReadData", ReadDataOut, 32'hDEAD_BEEF);
    chk("lit load WBOut", {30'd0, WBOut}, 32'd3);

    // Store, immediate ack; returned MemRData must not leak.
    runInstr("store_ack1", 2'b00, 2'b01, 32'h200, 32'hCAFE_F00D, 5'd0, 32'h1111_2222, 1);
    chk("lit store ReadData", ReadDataOut, 32'd0);

    // Back-to-back load where ack coincides with the last allowed cycle.
    runInstr("load_ack4", 2'b11, 2'b10, 32'h104, 32'h0, 5'd7, 32'h0BAD_F00D, 4);
    chk("lit ackwins AccessErr", {31'd0, AccessErr}, 32'd0);
    chk("lit ackwins ReadData", ReadDataOut, 32'h0BAD_F00D);

    // Timeout: MemAck never arrives.
    runInstr("load_timeout", 2'b11, 2'b10, 32'h108, 32'h0, 5'd3, 32'h7777_7777, 0);
    chk("lit timeout AccessErr", {31'd0, AccessErr}, 32'd1);
    chk("lit timeout WBOut", {30'd0, WBOut}, 32'd0);

    // Illegal accesses.
    runInstr("load_misaligned", 2'b11, 2'b10, 32'h102, 32'h0, 5'd5, 32'h0, 1);
    runInstr("read_write_both", 2'b10, 2'b11, 32'h100, 32'h0, 5'd6, 32'h0, 1);
    runInstr("store_misaligned", 2'b00, 2'b01, 32'h201, 32'h1234_5678, 5'd0, 32'h0, 1);

    // Sticky flag across further ALU ops.
    for (int i = 0; i < 10; i++)
      runInstr("alu_sticky", 2'b10, 2'b00, 32'h10 * i, 32'h0, 5'(i), 32'h0, 0);
    chk("lit sticky AccessErr", {31'd0, AccessErr}, 32'd1);

    // Reset in the middle of an access.
    checkEn = 1'b0;
    WBIn = 2'b11; MIn = 2'b10; ALUResultIn = 32'h300; RegDstIn = 5'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midbusy MemReq", {31'd0, MemReq}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst MemReq",    {31'd0, MemReq},    32'd0);
    chk("rst MemAddr",   MemAddr,            32'd0);
    chk("rst Stall",     {31'd0, Stall},     32'd0);
    chk("rst AccessErr", {31'd0, AccessErr}, 32'd0);
    chk("rst WBOut",     {30'd0, WBOut},     32'd0);
    chk("rst ALURes",    ALUResultOut,       32'd0);
    MIn = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    clearModel();
    checkEn = 1'b1;

    runInstr("alu_after_rst", 2'b10, 2'b00, 32'hABCD_0000, 32'h0, 5'd31, 32'h0, 0);
    runInstr("store_after_rst", 2'b00, 2'b01, 32'h400, 32'h0F0F_0F0F, 5'd0, 32'h0, 2);
    chk("lit after rst AccessErr", {31'd0, AccessErr}, 32'd0);

    @(negedge clk);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the EX/MEM control and data fields, runs the data-memory access over a req/ack handshake, and stalls the upstream pipeline while the access is outstanding.
- Registers the MEM/WB pipeline fields consumed by write-back.
- Detects illegal or misaligned accesses and memory timeouts, squashes them into bubbles, and reports them through a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without MemAck before the access is abandoned; legal range 1..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- WBIn  in  2  from EX/MEM; [1]=RegWrite, [0]=MemToReg.
- MIn  in  2  from EX/MEM; [1]=MemRead, [0]=MemWrite.
- ALUResultIn  in  32  from EX/MEM; memory byte address or ALU result.
- WriteDataIn  in  32  from EX/MEM; store data.
- RegDstIn  in  5  from EX/MEM; destination register.
- MemReq  out  1  data-memory request.
- MemWe  out  1  1=write, 0=read; valid while MemReq=1.
- MemAddr  out  32  word-aligned byte address; valid while MemReq=1.
- MemWData  out  32  store data; valid while MemReq=1.
- MemRData  in  32  load data; sampled in the cycle MemAck=1.
- MemAck  in  1  single-cycle completion strobe.
- Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- AccessErr  out  1  sticky error flag.
- WBOut  out  2  MEM/WB control bits.
- ReadDataOut  out  32  MEM/WB load data.
- ALUResultOut  out  32  MEM/WB ALU result.
- RegDstOut  out  5  MEM/WB destination register.

Behaviour:
- Reset: rst=1 asynchronously forces the following, overriding everything including mid-access:
  - state=IDLE, counter=0, AccessErr=0.
  - WBOut/ReadDataOut/ALUResultOut/RegDstOut=0.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0, Stall=0 from the same instant.
- Definitions:
  - acc = MIn[1] ^ MIn[0].
  - bad = (MIn==2'b11) or (acc and ALUResultIn[1:0]!=0).
- Bubble: MEM/WB loads all-zero fields; WBOut=0 guarantees no register write.
- State IDLE:
  - MemReq=0.
  - MemAck is ignored.
  - Counter cleared.
  - Sub-cases, evaluated each edge:
    - no access (MIn==0): Stall=0; MEM/WB captures WBIn, ReadDataOut=0, ALUResultIn, RegDstIn; zero-latency pass-through.
    - bad: Stall=0; bubble; AccessErr<=1; no request issued.
    - acc and not bad: Stall=1 (combinational); bubble; next state BUSY.
- State BUSY:
  - MemReq=1, MemWe=MIn[0], MemAddr=ALUResultIn, MemWData=WriteDataIn. Inputs are held stable by Stall.
  - MemAck=1:
    - Stall=0.
    - MEM/WB captures WBIn, ALUResultIn, RegDstIn.
    - ReadDataOut=MemRData if read, else 0.
    - Next state IDLE.
  - MemAck=0 and counter==TIMEOUT_CYCLES-1:
    - Stall=0; bubble; AccessErr<=1; next state IDLE.
    - The instruction is dropped; MemReq falls at the edge.
  - Otherwise: Stall=1; bubble; counter+1; stay in BUSY.
- Timing:
  - Minimum memory-op latency is 2 cycles (IDLE cycle plus ack in the first BUSY cycle).
  - An ack in cycle k of BUSY gives k+1 cycles total.
- MemAck arriving together with timeout expiry: ack wins.
- A new EX/MEM instruction is only examined in IDLE, so there is at most one outstanding access.
- Back-to-back memory ops re-enter BUSY after one IDLE cycle.
- AccessErr stays at 1 until reset.

Test Plan:
- Reset: rst pulse mid-BUSY with MemReq=1 -> MemReq, Stall, AccessErr and all MEM/WB fields 0 immediately; state IDLE.
- ALU op pass-through:
  - Stimulus: WBIn=2'b10, MIn=0, ALUResultIn=32'h0000_1234, RegDstIn=5'd9.
  - Response: after 1 edge WBOut=2'b10, ALUResultOut=32'h1234, RegDstOut=9, ReadDataOut=0; Stall never 1.
- Load, ack in 3rd BUSY cycle:
  - Stimulus: MIn=2'b10, WBIn=2'b11, ALUResultIn=32'h100, MemRData=32'hDEAD_BEEF at ack.
  - Response: Stall high 3 cycles; MemReq high 3 cycles with MemAddr=32'h100, MemWe=0; then WBOut=2'b11, ReadDataOut=32'hDEADBEEF; intermediate MEM/WB WBOut=0.
- Store, immediate ack:
  - Stimulus: MIn=2'b01, WriteDataIn=32'hCAFE_F00D, ALUResultIn=32'h200.
  - Response: Stall high 1 cycle; MemWe=1, MemWData=32'hCAFEF00D for one cycle; ReadDataOut=0.
- Errors:
  - MIn=2'b10 with ALUResultIn=32'h102 -> no MemReq, bubble, AccessErr=1.
  - MIn=2'b11 -> same response.
  - AccessErr stays 1 over 10 further cycles.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load with MemAck held 0.
  - Response: MemReq high exactly 4 cycles; Stall drops after 5 total cycles; AccessErr=1; WBOut=0.
  - Repeat with MemAck=1 in the 4th BUSY cycle -> normal completion, AccessErr stays 0.
